// File: rtl/pipelined_controller.sv
// Stage-aware MIPS main controller: ID decode, ID/EX, EX/MEM, MEM/WB
// control registers, load-use stall, branch flush, hold, stall counter.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   id_valid            IF/ID holds a real instruction
//   opcode, func        instr[31:26], instr[5:0]
//   rs, rt, rd          register fields of the ID instruction
//   hold                global freeze of every stage register
//   flush               kill the ID instruction (bubble into EX)
//   stall_id            comb: freeze PC and IF/ID this cycle
//   ex_*                EX-stage control from ID/EX
//   mem_read/mem_write  MEM-stage control from EX/MEM
//   wb_*                WB-stage control from MEM/WB
//   illegal             undecodable instruction sits in EX
//   stall_count         saturating count of non-hold stall cycles

package pipelined_controller_pkg;
  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_NOR  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_SLL  = 4'd9;
  localparam logic [3:0] ALU_SRL  = 4'd10;
  localparam logic [3:0] ALU_SRA  = 4'd11;
  localparam logic [3:0] ALU_LUI  = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;
endpackage

module pipelined_controller
  import pipelined_controller_pkg::*;
#(
  parameter int ALUOP_W = 4,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic [RADDR_W-1:0] rs,
  input  logic [RADDR_W-1:0] rt,
  input  logic [RADDR_W-1:0] rd,
  input  logic               hold,
  input  logic               flush,
  output logic               stall_id,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic               ex_alusrc,
  output logic               ex_shift,
  output logic [1:0]         ex_branch,
  output logic [1:0]         ex_jump,
  output logic [RADDR_W-1:0] ex_dst,
  output logic               mem_read,
  output logic               mem_write,
  output logic               wb_regwrite,
  output logic               wb_memtoreg,
  output logic [RADDR_W-1:0] wb_dst,
  output logic               illegal,
  output logic [CNT_W-1:0]   stall_count
);

  typedef struct packed {
    logic [ALUOP_W-1:0] aluop;
    logic               alusrc;
    logic               shift;
    logic [1:0]         branch;
    logic [1:0]         jump;
    logic [RADDR_W-1:0] dst;
    logic               memread;
    logic               memwrite;
    logic               regwrite;
    logic               memtoreg;
    logic               illegal;
  } id_ex_t;

  typedef struct packed {
    logic               memread;
    logic               memwrite;
    logic               regwrite;
    logic               memtoreg;
    logic [RADDR_W-1:0] dst;
  } ex_mem_t;

  typedef struct packed {
    logic               regwrite;
    logic               memtoreg;
    logic [RADDR_W-1:0] dst;
  } mem_wb_t;

  function automatic logic [ALUOP_W-1:0] op_w(
    input logic [3:0] x
  );
    return ALUOP_W'(x);
  endfunction

  id_ex_t             dec;
  logic               use_rs;
  logic               use_rt;
  logic               legal;
  logic [RADDR_W-1:0] wdst;
  logic               load_use;

  id_ex_t             idex_q, idex_d;
  ex_mem_t            exmem_q, exmem_d;
  mem_wb_t            memwb_q, memwb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // dst stays 0 for instructions that write no register
  always_comb begin
    dec    = '0;
    use_rs = 1'b1;
    use_rt = 1'b0;
    legal  = 1'b1;
    wdst   = '0;
    unique case (opcode)
      OP_RTYPE: begin
        use_rt = 1'b1;
        wdst   = rd;
        unique case (func)
          F_ADD, F_ADDU: dec.aluop = op_w(ALU_ADD);
          F_SUB, F_SUBU: dec.aluop = op_w(ALU_SUB);
          F_AND:  dec.aluop = op_w(ALU_AND);
          F_OR:   dec.aluop = op_w(ALU_OR);
          F_XOR:  dec.aluop = op_w(ALU_XOR);
          F_NOR:  dec.aluop = op_w(ALU_NOR);
          F_SLT:  dec.aluop = op_w(ALU_SLT);
          F_SLTU: dec.aluop = op_w(ALU_SLTU);
          F_SLL: begin
            dec.aluop = op_w(ALU_SLL);
            dec.shift = 1'b1;
          end
          F_SRL: begin
            dec.aluop = op_w(ALU_SRL);
            dec.shift = 1'b1;
          end
          F_SRA: begin
            dec.aluop = op_w(ALU_SRA);
            dec.shift = 1'b1;
          end
          F_JR: begin
            dec.jump = 2'b10;
            wdst     = '0;
          end
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        dec.aluop  = op_w(ALU_ADD);
        dec.alusrc = 1'b1;
        wdst       = rt;
      end
      OP_SLTI: begin
        dec.aluop  = op_w(ALU_SLT);
        dec.alusrc = 1'b1;
        wdst       = rt;
      end
      OP_SLTIU: begin
        dec.aluop  = op_w(ALU_SLTU);
        dec.alusrc = 1'b1;
        wdst       = rt;
      end
      OP_ANDI: begin
        dec.aluop  = op_w(ALU_AND);
        dec.alusrc = 1'b1;
        wdst       = rt;
      end
      OP_ORI: begin
        dec.aluop  = op_w(ALU_OR);
        dec.alusrc = 1'b1;
        wdst       = rt;
      end
      OP_XORI: begin
        dec.aluop  = op_w(ALU_XOR);
        dec.alusrc = 1'b1;
        wdst       = rt;
      end
      OP_LUI: begin
        dec.aluop  = op_w(ALU_LUI);
        dec.alusrc = 1'b1;
        wdst       = rt;
      end
      OP_LW: begin
        dec.aluop    = op_w(ALU_ADD);
        dec.alusrc   = 1'b1;
        dec.memread  = 1'b1;
        dec.memtoreg = 1'b1;
        wdst         = rt;
      end
      OP_SW: begin
        dec.aluop    = op_w(ALU_ADD);
        dec.alusrc   = 1'b1;
        dec.memwrite = 1'b1;
        use_rt       = 1'b1;
      end
      OP_BEQ: begin
        dec.aluop  = op_w(ALU_SUB);
        dec.branch = 2'b01;
        use_rt     = 1'b1;
      end
      OP_BNE: begin
        dec.aluop  = op_w(ALU_SUB);
        dec.branch = 2'b10;
        use_rt     = 1'b1;
      end
      OP_J: begin
        dec.jump = 2'b01;
        use_rs   = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    dec.dst      = wdst;
    dec.regwrite = (wdst != '0);
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
      use_rs      = 1'b0;
      use_rt      = 1'b0;
    end
  end

  // ex_dst is 0 for LW $0, so a load to $0 never stalls
  always_comb begin
    load_use = 1'b0;
    if (id_valid && idex_q.memread &&
        idex_q.dst != '0) begin
      load_use = (use_rs && rs == idex_q.dst) ||
                 (use_rt && rt == idex_q.dst);
    end
  end

  assign stall_id = hold | (~flush & load_use);

  always_comb begin
    idex_d  = idex_q;
    exmem_d = exmem_q;
    memwb_d = memwb_q;
    cnt_d   = cnt_q;
    if (!hold) begin
      idex_d = '0;
      if (id_valid && !flush && !load_use)
        idex_d = dec;
      exmem_d.memread  = idex_q.memread;
      exmem_d.memwrite = idex_q.memwrite;
      exmem_d.regwrite = idex_q.regwrite;
      exmem_d.memtoreg = idex_q.memtoreg;
      exmem_d.dst      = idex_q.dst;
      memwb_d.regwrite = exmem_q.regwrite;
      memwb_d.memtoreg = exmem_q.memtoreg;
      memwb_d.dst      = exmem_q.dst;
      if (load_use && !flush && cnt_q != '1)
        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
      cnt_q   <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_aluop    = idex_q.aluop;
  assign ex_alusrc   = idex_q.alusrc;
  assign ex_shift    = idex_q.shift;
  assign ex_branch   = idex_q.branch;
  assign ex_jump     = idex_q.jump;
  assign ex_dst      = idex_q.dst;
  assign illegal     = idex_q.illegal;
  assign mem_read    = exmem_q.memread;
  assign mem_write   = exmem_q.memwrite;
  assign wb_regwrite = memwb_q.regwrite;
  assign wb_memtoreg = memwb_q.memtoreg;
  assign wb_dst      = memwb_q.dst;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_pipelined_controller.sv
// Testbench for pipelined_controller: directed vectors, an
// instruction-level pipeline model and hand-computed spot checks.
module tb_pipelined_controller;
  import pipelined_controller_pkg::*;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [5:0] opcode;
  logic [5:0] func;
  logic [4:0] rs, rt, rd;
  logic       hold, flush;
  logic       stall_id;
  logic [3:0] ex_aluop;
  logic       ex_alusrc, ex_shift;
  logic [1:0] ex_branch, ex_jump;
  logic [4:0] ex_dst;
  logic       mem_read, mem_write;
  logic       wb_regwrite, wb_memtoreg;
  logic [4:0] wb_dst;
  logic       illegal;
  logic [CNT_W-1:0] stall_count;

  pipelined_controller #(
    .ALUOP_W(4), .RADDR_W(5), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .opcode(opcode),
    .func(func), .rs(rs), .rt(rt), .rd(rd),
    .hold(hold), .flush(flush),
    .stall_id(stall_id),
    .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc),
    .ex_shift(ex_shift), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_dst(ex_dst),
    .mem_read(mem_read), .mem_write(mem_write),
    .wb_regwrite(wb_regwrite),
    .wb_memtoreg(wb_memtoreg),
    .wb_dst(wb_dst), .illegal(illegal),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int alu; int src; int sh; int br; int jp;
    int dst; int mr; int mw; int rw; int mtr;
    int ill; int urs; int urt;
  } mctl_t;

  mctl_t m_ex, m_mem, m_wb;
  int    m_cnt;
  int    vectors = 0;
  int    miscompares = 0;
  bit    chk_en = 1'b0;
  bit    last_stall;

  task automatic chk(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic mctl_t bubble();
    mctl_t c = '{default: 0};
    return c;
  endfunction

  // Instruction meaning: what each MIPS instruction asks of
  // every later stage, plus which source fields it reads.
  function automatic mctl_t mdec(logic [5:0] op,
      logic [5:0] fn, logic [4:0] s, logic [4:0] t,
      logic [4:0] d);
    mctl_t c = '{default: 0};
    bit ok = 1;
    int wd = 0;
    case (op)
      6'h00: begin
        c.urt = 1; wd = int'(d);
        case (fn)
          6'h20, 6'h21: c.alu = ALU_ADD;
          6'h22, 6'h23: c.alu = ALU_SUB;
          6'h24: c.alu = ALU_AND;
          6'h25: c.alu = ALU_OR;
          6'h26: c.alu = ALU_XOR;
          6'h27: c.alu = ALU_NOR;
          6'h2A: c.alu = ALU_SLT;
          6'h2B: c.alu = ALU_SLTU;
          6'h00: begin c.alu = ALU_SLL; c.sh = 1; end
          6'h02: begin c.alu = ALU_SRL; c.sh = 1; end
          6'h03: begin c.alu = ALU_SRA; c.sh = 1; end
          6'h08: begin c.jp = 2; wd = 0; end
          default: ok = 0;
        endcase
      end
      6'h08, 6'h09: begin
        c.alu = ALU_ADD; c.src = 1; wd = int'(t);
      end
      6'h0A: begin c.alu = ALU_SLT; c.src = 1; wd = int'(t); end
      6'h0B: begin c.alu = ALU_SLTU; c.src = 1; wd = int'(t); end
      6'h0C: begin c.alu = ALU_AND; c.src = 1; wd = int'(t); end
      6'h0D: begin c.alu = ALU_OR; c.src = 1; wd = int'(t); end
      6'h0E: begin c.alu = ALU_XOR; c.src = 1; wd = int'(t); end
      6'h0F: begin c.alu = ALU_LUI; c.src = 1; wd = int'(t); end
      6'h23: begin
        c.alu = ALU_ADD; c.src = 1; c.mr = 1; c.mtr = 1;
        wd = int'(t);
      end
      6'h2B: begin
        c.alu = ALU_ADD; c.src = 1; c.mw = 1; c.urt = 1;
      end
      6'h04: begin c.alu = ALU_SUB; c.br = 1; c.urt = 1; end
      6'h05: begin c.alu = ALU_SUB; c.br = 2; c.urt = 1; end
      6'h02: c.jp = 1;
      default: ok = 0;
    endcase
    if (!ok) begin
      c = '{default: 0};
      c.ill = 1;
    end else begin
      c.urs = (op != 6'h02) ? 1 : 0;
      c.dst = wd;
      c.rw  = (wd != 0) ? 1 : 0;
    end
    return c;
  endfunction

  function automatic bit mlu();
    mctl_t d = mdec(opcode, func, rs, rt, rd);
    if (id_valid !== 1'b1) return 0;
    if (m_ex.mr != 1 || m_ex.dst == 0) return 0;
    return (d.urs == 1 && int'(rs) == m_ex.dst) ||
           (d.urt == 1 && int'(rt) == m_ex.dst);
  endfunction

  task automatic mreset();
    m_ex = bubble(); m_mem = bubble(); m_wb = bubble();
    m_cnt = 0;
  endtask

  task automatic madv();
    bit lu;
    if (!rst_n) begin
      mreset();
    end else if (!hold) begin
      lu = mlu();
      if (!flush && lu && m_cnt < CMAX) m_cnt++;
      m_wb  = m_mem;
      m_mem = m_ex;
      if (id_valid && !flush && !lu)
        m_ex = mdec(opcode, func, rs, rt, rd);
      else
        m_ex = bubble();
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall_id", int'(stall_id),
          int'(hold || (!flush && mlu())));
      chk("ex_aluop", int'(ex_aluop), m_ex.alu);
      chk("ex_alusrc", int'(ex_alusrc), m_ex.src);
      chk("ex_shift", int'(ex_shift), m_ex.sh);
      chk("ex_branch", int'(ex_branch), m_ex.br);
      chk("ex_jump", int'(ex_jump), m_ex.jp);
      chk("ex_dst", int'(ex_dst), m_ex.dst);
      chk("illegal", int'(illegal), m_ex.ill);
      chk("mem_read", int'(mem_read), m_mem.mr);
      chk("mem_write", int'(mem_write), m_mem.mw);
      chk("wb_regwrite", int'(wb_regwrite), m_wb.rw);
      chk("wb_memtoreg", int'(wb_memtoreg), m_wb.mtr);
      chk("wb_dst", int'(wb_dst), m_wb.dst);
      chk("stall_count", int'(stall_count), m_cnt);
    end
  end

  task automatic cyc(bit v, logic [5:0] op, logic [5:0] fn,
      logic [4:0] s, logic [4:0] t, logic [4:0] d,
      bit h, bit f);
    id_valid = v; opcode = op; func = fn;
    rs = s; rt = t; rd = d; hold = h; flush = f;
    #2 last_stall = stall_id;
    @(posedge clk);
    madv();
    #1;
  endtask

  task automatic nop();
    cyc(0, 6'h00, 6'h00, 0, 0, 0, 0, 0);
  endtask

  task automatic lw5();
    cyc(1, 6'h23, 6'h00, 1, 5, 0, 0, 0);
  endtask

  task automatic add_5();
    cyc(1, 6'h00, 6'h20, 5, 2, 6, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 0; opcode = 0; func = 0;
    rs = 0; rt = 0; rd = 0; hold = 0; flush = 0;
    mreset();
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    nop();
    chk("rst_cnt", int'(stall_count), 0);
    chk("rst_aluop", int'(ex_aluop), 0);
    chk("rst_wb", int'(wb_regwrite), 0);
    rst_n = 1'b1;
    nop();

    // ADD $3,$1,$2
    cyc(1, 6'h00, 6'h20, 1, 2, 3, 0, 0);
    chk("t1_stall", int'(last_stall), 0);
    chk("t1_aluop", int'(ex_aluop), 1);
    chk("t1_dst", int'(ex_dst), 3);
    nop();
    nop();
    chk("t1_wb_rw", int'(wb_regwrite), 1);
    chk("t1_wb_dst", int'(wb_dst), 3);

    // LW $5 then ADD $6,$5,$2
    lw5();
    chk("t2_lw_src", int'(ex_alusrc), 1);
    add_5();
    chk("t2_stall", int'(last_stall), 1);
    chk("t2_bubble", int'(ex_aluop), 0);
    chk("t2_memrd", int'(mem_read), 1);
    chk("t2_cnt", int'(stall_count), 1);
    add_5();
    chk("t2_nostall", int'(last_stall), 0);
    chk("t2_aluop", int'(ex_aluop), 1);
    chk("t2_dst", int'(ex_dst), 6);
    chk("t2_wb_mtr", int'(wb_memtoreg), 1);
    chk("t2_wb_dst", int'(wb_dst), 5);

    // LW $5 then SW $7,0($5): rs match
    lw5();
    cyc(1, 6'h2B, 6'h00, 5, 7, 0, 0, 0);
    chk("t3_sw_stall", int'(last_stall), 1);
    chk("t3_cnt", int'(stall_count), 2);
    cyc(1, 6'h2B, 6'h00, 5, 7, 0, 0, 0);
    nop();
    chk("t3_memwr", int'(mem_write), 1);
    // LW $0 then ADD $6,$0,$2
    cyc(1, 6'h23, 6'h00, 1, 0, 0, 0, 0);
    cyc(1, 6'h00, 6'h20, 0, 2, 6, 0, 0);
    chk("t3_r0_stall", int'(last_stall), 0);
    // J does not read rs
    lw5();
    cyc(1, 6'h02, 6'h00, 5, 5, 0, 0, 0);
    chk("t3_j_stall", int'(last_stall), 0);
    chk("t3_j", int'(ex_jump), 1);
    // ADDI does not read rt
    lw5();
    cyc(1, 6'h08, 6'h00, 1, 5, 0, 0, 0);
    chk("t3_addi_stall", int'(last_stall), 0);
    // invalid ID slot never stalls
    lw5();
    cyc(0, 6'h00, 6'h20, 5, 2, 6, 0, 0);
    chk("t3_inv_stall", int'(last_stall), 0);
    chk("t3_inv_bub", int'(ex_aluop), 0);
    // BEQ $1,$5: rt match
    lw5();
    cyc(1, 6'h04, 6'h00, 1, 5, 0, 0, 0);
    chk("t3_beq_stall", int'(last_stall), 1);
    chk("t3_cnt3", int'(stall_count), 3);
    cyc(1, 6'h04, 6'h00, 1, 5, 0, 0, 0);
    chk("t3_beq_br", int'(ex_branch), 1);
    chk("t3_beq_alu", int'(ex_aluop), 2);

    // BEQ in EX, flush kills ADDI $9 in ID
    cyc(1, 6'h08, 6'h00, 1, 9, 0, 0, 1);
    chk("t4_stall", int'(last_stall), 0);
    chk("t4_bubble", int'(ex_aluop), 0);
    chk("t4_dst", int'(ex_dst), 0);
    nop();
    nop();
    chk("t4_wb_rw", int'(wb_regwrite), 0);
    // flush beats load-use
    lw5();
    cyc(1, 6'h00, 6'h20, 5, 2, 6, 0, 1);
    chk("t4_fl_stall", int'(last_stall), 0);
    chk("t4_fl_cnt", int'(stall_count), 3);

    // hold during load-use
    lw5();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 6'h00, 6'h20, 5, 2, 6, 1, 0);
      chk("t5_hold_stall", int'(last_stall), 1);
      chk("t5_hold_cnt", int'(stall_count), 3);
      chk("t5_hold_dst", int'(ex_dst), 5);
      chk("t5_hold_mr", int'(mem_read), 0);
    end
    add_5();
    chk("t5_rel_stall", int'(last_stall), 1);
    chk("t5_rel_cnt", int'(stall_count), 4);
    chk("t5_rel_bub", int'(ex_aluop), 0);
    add_5();
    chk("t5_add", int'(ex_aluop), 1);
    chk("t5_add_dst", int'(ex_dst), 6);

    // illegal opcode and illegal func
    cyc(1, 6'h3F, 6'h00, 0, 0, 0, 0, 0);
    chk("t6_ill", int'(illegal), 1);
    chk("t6_ill_alu", int'(ex_aluop), 0);
    nop();
    chk("t6_ill_end", int'(illegal), 0);
    chk("t6_ill_mw", int'(mem_write), 0);
    cyc(1, 6'h00, 6'h3F, 1, 2, 3, 0, 0);
    chk("t6_func_ill", int'(illegal), 1);
    nop();
    nop();
    chk("t6_ill_wb", int'(wb_regwrite), 0);

    // saturation of stall_count
    for (int i = 0; i < 13; i++) begin
      lw5();
      add_5();
    end
    chk("sat_cnt", int'(stall_count), CMAX);

    // reset mid-stream
    cyc(1, 6'h00, 6'h20, 1, 2, 3, 0, 0);
    cyc(1, 6'h23, 6'h00, 1, 4, 0, 0, 0);
    rst_n = 1'b0;
    mreset();
    #1;
    chk("mr_alu", int'(ex_aluop), 0);
    chk("mr_dst", int'(ex_dst), 0);
    chk("mr_memrd", int'(mem_read), 0);
    chk("mr_wb", int'(wb_regwrite), 0);
    chk("mr_cnt", int'(stall_count), 0);
    nop();
    rst_n = 1'b1;
    cyc(1, 6'h00, 6'h20, 1, 2, 3, 0, 0);
    chk("mr_add", int'(ex_aluop), 1);
    chk("mr_add_dst", int'(ex_dst), 3);
    nop();
    nop();
    nop();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
